// File: rtl/priority_encoder_pipe.sv
// Pipelined priority encoder with a valid/ready handshake on both sides and a single registered result stage.
// Define PRIORITY_ENCODER_ROUND_ROBIN_EN to build the rotating-pointer (round-robin) search instead of fixed priority.

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module priority_encoder_pipe #(
  parameter int unsigned INPUT_SIZE = 8,
  parameter int unsigned DIRECTION  = 0,
  localparam int unsigned BW_INPUT_SIZE = `CLOG2(INPUT_SIZE)
) (
  input  logic                     clock_i,
  input  logic                     resetn_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [INPUT_SIZE-1:0]    encoding_i,
  output logic                     grant_valid_o,
  input  logic                     grant_ready_i,
  output logic [BW_INPUT_SIZE-1:0] binary_o,
  output logic [INPUT_SIZE-1:0]    onehot_o,
  output logic                     none_o
);

  localparam logic [BW_INPUT_SIZE-1:0] LAST_IDX = BW_INPUT_SIZE'(INPUT_SIZE - 1);

  logic                     accept;
  logic                     found;
  logic [BW_INPUT_SIZE-1:0] win;
  logic [BW_INPUT_SIZE-1:0] binary_next;
  logic [INPUT_SIZE-1:0]    onehot_next;

  function automatic logic [BW_INPUT_SIZE-1:0] lowest_set(input logic [INPUT_SIZE-1:0] v);
    logic [BW_INPUT_SIZE-1:0] r;
    r = '0;
    for (int i = INPUT_SIZE - 1; i >= 0; i--) begin
      if (v[i]) r = BW_INPUT_SIZE'(i);
    end
    return r;
  endfunction

  function automatic logic [BW_INPUT_SIZE-1:0] highest_set(input logic [INPUT_SIZE-1:0] v);
    logic [BW_INPUT_SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (v[i]) r = BW_INPUT_SIZE'(i);
    end
    return r;
  endfunction

  assign req_ready_o = !grant_valid_o || grant_ready_i;
  assign accept      = req_valid_i && req_ready_o;

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  logic [BW_INPUT_SIZE-1:0] ptr;
  logic [BW_INPUT_SIZE-1:0] ptr_next;
  logic [INPUT_SIZE-1:0]    window;

  // Requests on the ptr side of the ring win first; otherwise the search wraps to the full vector.
  always_comb begin
    window   = '0;
    win      = '0;
    ptr_next = ptr;
    found    = |encoding_i;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (DIRECTION == 0) window[i] = encoding_i[i] && (BW_INPUT_SIZE'(i) >= ptr);
      else                window[i] = encoding_i[i] && (BW_INPUT_SIZE'(i) <= ptr);
    end
    if (DIRECTION == 0) win = (|window) ? lowest_set(window)  : lowest_set(encoding_i);
    else                win = (|window) ? highest_set(window) : highest_set(encoding_i);
    if (found) begin
      if (DIRECTION == 0) ptr_next = (win == LAST_IDX) ? '0 : win + BW_INPUT_SIZE'(1);
      else                ptr_next = (win == '0) ? LAST_IDX : win - BW_INPUT_SIZE'(1);
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ptr <= (DIRECTION == 0) ? '0 : LAST_IDX;
    end else if (accept) begin
      ptr <= ptr_next;
    end
  end
`else
  always_comb begin
    found = |encoding_i;
    win   = (DIRECTION == 0) ? lowest_set(encoding_i) : highest_set(encoding_i);
  end
`endif

  // All-zero vectors report index 0 (ascending) or all ones (descending).
  always_comb begin
    binary_next = found ? win : ((DIRECTION == 0) ? '0 : '1);
    onehot_next = found ? (INPUT_SIZE'(1) << win) : '0;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      grant_valid_o <= 1'b0;
      binary_o      <= '0;
      onehot_o      <= '0;
      none_o        <= 1'b0;
    end else if (accept) begin
      grant_valid_o <= 1'b1;
      binary_o      <= binary_next;
      onehot_o      <= onehot_next;
      none_o        <= !found;
    end else if (grant_ready_i) begin
      grant_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_priority_encoder_pipe.sv
// Scoreboard bench for priority_encoder_pipe: an 8-wide ascending and a 6-wide descending instance share one handshake.
// Expected results come from a ring-search model; round-robin expectations follow PRIORITY_ENCODER_ROUND_ROBIN_EN.

module tb_priority_encoder_pipe;

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int         bin;
    logic [7:0] oh;
    bit         none;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       grant_ready;
  logic [7:0] enc;

  logic       ready_a, gv_a, none_a;
  logic [2:0] bin_a;
  logic [7:0] oh_a;
  logic       ready_b, gv_b, none_b;
  logic [2:0] bin_b;
  logic [5:0] oh_b;

  exp_t qa[$];
  exp_t qb[$];
  bit   mgv;
  int   ptr_a;
  int   ptr_b;
  int   n_err;
  int   n_checks;

  priority_encoder_pipe #(.INPUT_SIZE(8), .DIRECTION(0)) u_dut_a (
    .clock_i(clk), .resetn_i(rst_n), .req_valid_i(req_valid), .req_ready_o(ready_a),
    .encoding_i(enc), .grant_valid_o(gv_a), .grant_ready_i(grant_ready),
    .binary_o(bin_a), .onehot_o(oh_a), .none_o(none_a)
  );

  priority_encoder_pipe #(.INPUT_SIZE(6), .DIRECTION(1)) u_dut_b (
    .clock_i(clk), .resetn_i(rst_n), .req_valid_i(req_valid), .req_ready_o(ready_b),
    .encoding_i(enc[5:0]), .grant_valid_o(gv_b), .grant_ready_i(grant_ready),
    .binary_o(bin_b), .onehot_o(oh_b), .none_o(none_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Walk the ring from the start point; fixed mode always starts at the winning edge.
  function automatic int find_win(input int n, input int dir, input int ptr, input logic [7:0] e);
    int start;
    int idx;
    start = RR ? ptr : ((dir == 0) ? 0 : n - 1);
    for (int k = 0; k < n; k++) begin
      idx = (dir == 0) ? (start + k) % n : (start - k + n) % n;
      if (e[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic exp_t make_exp(input int w, input int dir);
    exp_t x;
    if (w < 0) begin
      x.bin  = (dir == 0) ? 0 : 7;
      x.oh   = 8'h00;
      x.none = 1'b1;
    end else begin
      x.bin  = w;
      x.oh   = 8'(1 << w);
      x.none = 1'b0;
    end
    return x;
  endfunction

  task automatic model_reset();
    mgv   = 1'b0;
    qa.delete();
    qb.delete();
    ptr_a = 0;
    ptr_b = 5;
  endtask

  task automatic cycle(input bit v, input logic [7:0] e, input bit r);
    bit acc;
    int w;
    req_valid   = v;
    enc         = e;
    grant_ready = r;
    #1;
    check("ready_a", 64'(ready_a), 64'(!mgv || r));
    check("ready_b", 64'(ready_b), 64'(!mgv || r));
    check("valid_a", 64'(gv_a), 64'(mgv));
    check("valid_b", 64'(gv_b), 64'(mgv));
    if (mgv && qa.size() > 0 && qb.size() > 0) begin
      check("bin_a",  64'(bin_a),  64'(qa[0].bin));
      check("oh_a",   64'(oh_a),   64'(qa[0].oh));
      check("none_a", 64'(none_a), 64'(qa[0].none));
      check("bin_b",  64'(bin_b),  64'(qb[0].bin));
      check("oh_b",   64'(oh_b),   64'(qb[0].oh));
      check("none_b", 64'(none_b), 64'(qb[0].none));
    end
    if (mgv && r) begin
      if (qa.size() > 0) void'(qa.pop_front());
      if (qb.size() > 0) void'(qb.pop_front());
    end
    acc = v && (!mgv || r);
    if (acc) begin
      w = find_win(8, 0, ptr_a, e);
      qa.push_back(make_exp(w, 0));
      if (RR && w >= 0) ptr_a = (w + 1) % 8;
      w = find_win(6, 1, ptr_b, e);
      qb.push_back(make_exp(w, 1));
      if (RR && w >= 0) ptr_b = (w + 5) % 6;
    end
    mgv = acc ? 1'b1 : (r ? 1'b0 : mgv);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    n_err       = 0;
    n_checks    = 0;
    clk         = 1'b0;
    rst_n       = 1'b1;
    req_valid   = 1'b0;
    grant_ready = 1'b0;
    enc         = 8'h00;
    model_reset();

    #1 rst_n = 1'b0;
    #1;
    check("rst_valid_a", 64'(gv_a), 64'd0);
    check("rst_bin_a",   64'(bin_a), 64'd0);
    check("rst_oh_a",    64'(oh_a), 64'd0);
    check("rst_none_a",  64'(none_a), 64'd0);
    check("rst_bin_b",   64'(bin_b), 64'd0);
    check("rst_ready_a", 64'(ready_a), 64'd1);
    check("rst_ready_b", 64'(ready_b), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic patterns, including an all-zero vector.
    cycle(1'b1, 8'b0110_1000, 1'b1);
    cycle(1'b1, 8'h00, 1'b1);
    // Backpressure with changing requests, then simultaneous drain and accept.
    cycle(1'b1, 8'h81, 1'b0);
    cycle(1'b1, 8'h42, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'h18, 1'b0);
    cycle(1'b1, 8'h24, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    // Repeated full vectors and the descending wrap sequence.
    repeat (7) cycle(1'b1, 8'h3F, 1'b1);
    cycle(1'b1, 8'h03, 1'b1);
    cycle(1'b1, 8'h03, 1'b1);
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'h03, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    // Random traffic with random backpressure.
    for (int i = 0; i < 80; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Reset while a result is stalled.
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h10, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid_a", 64'(gv_a), 64'd0);
    check("midrst_valid_b", 64'(gv_b), 64'd0);
    check("midrst_oh_a",    64'(oh_a), 64'd0);
    check("midrst_ready_a", 64'(ready_a), 64'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'hFF, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("sb_drained_a", 64'(qa.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder_pipe.md
PRIORITY_ENCODER_PIPE -- requirements
Module: priority_encoder_pipe

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 8: request vector width; legal range 2..256, power of two not required.
REQ-002 SHALL have parameter DIRECTION, default 0: 0 = lowest index wins, 1 = highest index wins.
REQ-003 SHALL derive localparam BW_INPUT_SIZE = `CLOG2(INPUT_SIZE).
REQ-004 SHALL have port clock_i  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port resetn_i  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  1: request vector valid.
REQ-007 SHALL have port req_ready_o  output  1: block can accept a request this cycle.
REQ-008 SHALL have port encoding_i  input  INPUT_SIZE: request bit vector.
REQ-009 SHALL have port grant_valid_o  output  1: registered result valid.
REQ-010 SHALL have port grant_ready_i  input  1: consumer accepts result.
REQ-011 SHALL have port binary_o  output  BW_INPUT_SIZE: winning index.
REQ-012 SHALL have port onehot_o  output  INPUT_SIZE: winning bit alone set; all zero when no winner.
REQ-013 SHALL have port none_o  output  1: accepted vector was all zero.

Function
REQ-014 SHALL accept a request on a cycle where req_valid_i and req_ready_o are both 1.
REQ-015 SHALL drive req_ready_o = !grant_valid_o || grant_ready_i (combinational; back-to-back throughput of one per cycle).
REQ-016 SHALL present the result of an accepted request on grant_valid_o/binary_o/onehot_o/none_o exactly 1 cycle after acceptance.
REQ-017 SHALL hold all result outputs stable while grant_valid_o=1 and grant_ready_i=0.
REQ-018 SHALL clear grant_valid_o on a cycle with grant_ready_i=1 and no new acceptance; on simultaneous drain and accept, SHALL load the new result with grant_valid_o kept at 1.
REQ-019 For an all-zero vector, SHALL set none_o=1, onehot_o=0, binary_o=0 (DIRECTION 0) or all ones (DIRECTION 1).
REQ-020 In fixed mode, SHALL select the lowest set index (DIRECTION 0) or highest set index (DIRECTION 1).
REQ-021 SHALL ignore encoding_i and req_valid_i when req_ready_o=0; the result register SHALL not change.

Reset
REQ-022 On resetn_i=0, SHALL immediately force grant_valid_o=0, binary_o=0, onehot_o=0, none_o=0, round-robin pointer to reset value.
REQ-023 Reset mid-transfer SHALL discard the pending result; no result is replayed after reset release.
REQ-024 req_ready_o SHALL read 1 during and directly after reset.

Configuration
REQ-025 Macro PRIORITY_ENCODER_ROUND_ROBIN_EN SHALL compile in round-robin mode; without it only fixed mode (REQ-020) exists and no pointer register is built.
REQ-026 With the macro, SHALL hold a pointer ptr (BW_INPUT_SIZE bits), reset to 0 (DIRECTION 0) or INPUT_SIZE-1 (DIRECTION 1).
REQ-027 With the macro, DIRECTION 0 SHALL search ascending from ptr, wrapping INPUT_SIZE-1 -> 0; DIRECTION 1 SHALL search descending from ptr, wrapping 0 -> INPUT_SIZE-1.
REQ-028 With the macro, on acceptance of a non-zero vector, ptr SHALL become winner+1 (DIRECTION 0) or winner-1 (DIRECTION 1), modulo INPUT_SIZE (non-power-of-two wrap exact).
REQ-029 With the macro, an all-zero acceptance SHALL leave ptr unchanged; REQ-019 output values apply unchanged.

Verification
REQ-030 Fixed, INPUT_SIZE=8, DIRECTION=0: accept 8'b0110_1000, grant_ready_i=1 -> next cycle grant_valid_o=1, binary_o=3, onehot_o=8'h08, none_o=0.
REQ-031 Fixed, DIRECTION=1: accept 8'h00 -> binary_o=3'b111, onehot_o=0, none_o=1.
REQ-032 Backpressure: result valid, grant_ready_i=0 for 4 cycles with changing encoding_i -> req_ready_o=0, outputs unchanged; then grant_ready_i=1 with req_valid_i=1 -> new result next cycle, grant_valid_o never drops.
REQ-033 Round-robin, INPUT_SIZE=6, DIRECTION=0: accept 6'h3F six times -> binary_o sequence 0,1,2,3,4,5, then 0 (wrap at 5).
REQ-034 Round-robin, DIRECTION=1, INPUT_SIZE=6: accept 6'b000011 twice, then 6'h00, then 6'b000011 -> binary_o 1,0, none_o=1 (binary_o=3'b111), then 1 (ptr wrapped to 5, unchanged by zero vector).
REQ-035 Assert resetn_i=0 asynchronously while grant_valid_o=1 and grant_ready_i=0 -> grant_valid_o=0 same cycle, ptr at reset value, first post-reset acceptance of 8'hFF yields binary_o=0 (DIRECTION 0).
